// File: rtl/axi_to_axi_lite_bridge.sv
// AXI4 slave to AXI4-Lite master bridge: one write and one read in flight,
// independent channels; bursts and atomics are answered locally with SLVERR.
module axi_to_axi_lite_bridge #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned AXI_USER_WIDTH = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        testmode_i,
    input  logic [AXI_ID_WIDTH-1:0]     in_aw_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   in_aw_addr,
    input  logic [7:0]                  in_aw_len,
    input  logic [2:0]                  in_aw_size,
    input  logic [1:0]                  in_aw_burst,
    input  logic                        in_aw_lock,
    input  logic [3:0]                  in_aw_cache,
    input  logic [2:0]                  in_aw_prot,
    input  logic [3:0]                  in_aw_qos,
    input  logic [3:0]                  in_aw_region,
    input  logic [5:0]                  in_aw_atop,
    input  logic [AXI_USER_WIDTH-1:0]   in_aw_user,
    input  logic                        in_aw_valid,
    output logic                        in_aw_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   in_w_data,
    input  logic [AXI_DATA_WIDTH/8-1:0] in_w_strb,
    input  logic                        in_w_last,
    input  logic [AXI_USER_WIDTH-1:0]   in_w_user,
    input  logic                        in_w_valid,
    output logic                        in_w_ready,
    output logic [AXI_ID_WIDTH-1:0]     in_b_id,
    output logic [1:0]                  in_b_resp,
    output logic [AXI_USER_WIDTH-1:0]   in_b_user,
    output logic                        in_b_valid,
    input  logic                        in_b_ready,
    input  logic [AXI_ID_WIDTH-1:0]     in_ar_id,
    input  logic [AXI_ADDR_WIDTH-1:0]   in_ar_addr,
    input  logic [7:0]                  in_ar_len,
    input  logic [2:0]                  in_ar_size,
    input  logic [1:0]                  in_ar_burst,
    input  logic                        in_ar_lock,
    input  logic [3:0]                  in_ar_cache,
    input  logic [2:0]                  in_ar_prot,
    input  logic [3:0]                  in_ar_qos,
    input  logic [3:0]                  in_ar_region,
    input  logic [AXI_USER_WIDTH-1:0]   in_ar_user,
    input  logic                        in_ar_valid,
    output logic                        in_ar_ready,
    output logic [AXI_ID_WIDTH-1:0]     in_r_id,
    output logic [AXI_DATA_WIDTH-1:0]   in_r_data,
    output logic [1:0]                  in_r_resp,
    output logic                        in_r_last,
    output logic [AXI_USER_WIDTH-1:0]   in_r_user,
    output logic                        in_r_valid,
    input  logic                        in_r_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   out_aw_addr,
    output logic [2:0]                  out_aw_prot,
    output logic                        out_aw_valid,
    input  logic                        out_aw_ready,
    output logic [AXI_DATA_WIDTH-1:0]   out_w_data,
    output logic [AXI_DATA_WIDTH/8-1:0] out_w_strb,
    output logic                        out_w_valid,
    input  logic                        out_w_ready,
    input  logic [1:0]                  out_b_resp,
    input  logic                        out_b_valid,
    output logic                        out_b_ready,
    output logic [AXI_ADDR_WIDTH-1:0]   out_ar_addr,
    output logic [2:0]                  out_ar_prot,
    output logic                        out_ar_valid,
    input  logic                        out_ar_ready,
    input  logic [AXI_DATA_WIDTH-1:0]   out_r_data,
    input  logic [1:0]                  out_r_resp,
    input  logic                        out_r_valid,
    output logic                        out_r_ready
);

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {W_IDLE, W_AW, W_DATA, W_B, W_RESP, W_ERR} wstate_t;
    typedef enum logic [2:0] {R_IDLE, R_AR, R_WAIT, R_RESP, R_ERR} rstate_t;

    wstate_t                     wstate;
    rstate_t                     rstate;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr_q, ar_addr_q;
    logic [AXI_ID_WIDTH-1:0]     aw_id_q, ar_id_q;
    logic [1:0]                  b_resp_q, r_resp_q;
    logic [AXI_DATA_WIDTH-1:0]   r_data_q;
    logic [7:0]                  r_cnt_q;

    // Sideband fields the Lite side has no use for.
    logic unused_fields;
    assign unused_fields = ^{testmode_i, in_aw_size, in_aw_burst, in_aw_lock, in_aw_cache,
                             in_aw_prot, in_aw_qos, in_aw_region, in_aw_user, in_w_user,
                             in_ar_size, in_ar_burst, in_ar_lock, in_ar_cache, in_ar_prot,
                             in_ar_qos, in_ar_region, in_ar_user};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wstate    <= W_IDLE;
            aw_addr_q <= '0;
            aw_id_q   <= '0;
            b_resp_q  <= '0;
        end else begin
            case (wstate)
                W_IDLE: if (in_aw_valid) begin
                    aw_addr_q <= in_aw_addr;
                    aw_id_q   <= in_aw_id;
                    if (in_aw_len == 8'd0 && in_aw_atop == 6'd0) wstate <= W_AW;
                    else                                          wstate <= W_ERR;
                end
                W_AW:   if (out_aw_ready) wstate <= W_DATA;
                W_DATA: if (in_w_valid && out_w_ready) wstate <= W_B;
                W_B:    if (out_b_valid) begin
                    b_resp_q <= out_b_resp;
                    wstate   <= W_RESP;
                end
                W_RESP: if (in_b_ready) wstate <= W_IDLE;
                W_ERR:  if (in_w_valid && in_w_last) begin
                    b_resp_q <= RESP_SLVERR;
                    wstate   <= W_RESP;
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rstate    <= R_IDLE;
            ar_addr_q <= '0;
            ar_id_q   <= '0;
            r_data_q  <= '0;
            r_resp_q  <= '0;
            r_cnt_q   <= '0;
        end else begin
            case (rstate)
                R_IDLE: if (in_ar_valid) begin
                    ar_addr_q <= in_ar_addr;
                    ar_id_q   <= in_ar_id;
                    r_cnt_q   <= in_ar_len;
                    // Error beats reuse the response registers with zero data.
                    r_data_q  <= '0;
                    r_resp_q  <= RESP_SLVERR;
                    if (in_ar_len == 8'd0) rstate <= R_AR;
                    else                   rstate <= R_ERR;
                end
                R_AR:   if (out_ar_ready) rstate <= R_WAIT;
                R_WAIT: if (out_r_valid) begin
                    r_data_q <= out_r_data;
                    r_resp_q <= out_r_resp;
                    rstate   <= R_RESP;
                end
                R_RESP: if (in_r_ready) rstate <= R_IDLE;
                R_ERR:  if (in_r_ready) begin
                    if (r_cnt_q == 8'd0) rstate <= R_IDLE;
                    else                 r_cnt_q <= r_cnt_q - 8'd1;
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    assign in_aw_ready  = (wstate == W_IDLE);
    assign out_aw_valid = (wstate == W_AW);
    assign out_aw_addr  = aw_addr_q;
    assign out_aw_prot  = '0;
    assign out_w_valid  = (wstate == W_DATA) && in_w_valid;
    assign out_w_data   = in_w_data;
    assign out_w_strb   = in_w_strb;
    assign in_w_ready   = (wstate == W_ERR) || ((wstate == W_DATA) && out_w_ready);
    assign out_b_ready  = (wstate == W_B);
    assign in_b_valid   = (wstate == W_RESP);
    assign in_b_id      = aw_id_q;
    assign in_b_resp    = b_resp_q;
    assign in_b_user    = '0;

    assign in_ar_ready  = (rstate == R_IDLE);
    assign out_ar_valid = (rstate == R_AR);
    assign out_ar_addr  = ar_addr_q;
    assign out_ar_prot  = '0;
    assign out_r_ready  = (rstate == R_WAIT);
    assign in_r_valid   = (rstate == R_RESP) || (rstate == R_ERR);
    assign in_r_id      = ar_id_q;
    assign in_r_data    = r_data_q;
    assign in_r_resp    = r_resp_q;
    assign in_r_last    = (rstate == R_RESP) || ((rstate == R_ERR) && (r_cnt_q == 8'd0));
    assign in_r_user    = '0;

endmodule

// File: tb/tb_axi_to_axi_lite_bridge.sv
// Directed bench for axi_to_axi_lite_bridge: the bench plays both the AXI
// master and the Lite slave, with a vector table plus corner-case sequences.
module tb_axi_to_axi_lite_bridge;

    logic        clk = 1'b0, rst_i = 1'b1, testmode_i = 1'b0;
    logic [7:0]  in_aw_id = '0, in_aw_len = '0, in_aw_user = '0;
    logic [31:0] in_aw_addr = '0;
    logic [2:0]  in_aw_size = '0, in_aw_prot = '0;
    logic [1:0]  in_aw_burst = '0;
    logic        in_aw_lock = 1'b0, in_aw_valid = 1'b0, in_aw_ready;
    logic [3:0]  in_aw_cache = '0, in_aw_qos = '0, in_aw_region = '0;
    logic [5:0]  in_aw_atop = '0;
    logic [31:0] in_w_data = '0;
    logic [3:0]  in_w_strb = '0;
    logic        in_w_last = 1'b0, in_w_valid = 1'b0, in_w_ready;
    logic [7:0]  in_w_user = '0;
    logic [7:0]  in_b_id, in_b_user;
    logic [1:0]  in_b_resp;
    logic        in_b_valid, in_b_ready = 1'b0;
    logic [7:0]  in_ar_id = '0, in_ar_len = '0, in_ar_user = '0;
    logic [31:0] in_ar_addr = '0;
    logic [2:0]  in_ar_size = '0, in_ar_prot = '0;
    logic [1:0]  in_ar_burst = '0;
    logic        in_ar_lock = 1'b0, in_ar_valid = 1'b0, in_ar_ready;
    logic [3:0]  in_ar_cache = '0, in_ar_qos = '0, in_ar_region = '0;
    logic [7:0]  in_r_id, in_r_user;
    logic [31:0] in_r_data;
    logic [1:0]  in_r_resp;
    logic        in_r_last, in_r_valid, in_r_ready = 1'b0;
    logic [31:0] out_aw_addr, out_ar_addr, out_w_data;
    logic [2:0]  out_aw_prot, out_ar_prot;
    logic        out_aw_valid, out_aw_ready = 1'b0;
    logic [3:0]  out_w_strb;
    logic        out_w_valid, out_w_ready = 1'b0;
    logic [1:0]  out_b_resp = '0;
    logic        out_b_valid = 1'b0, out_b_ready;
    logic        out_ar_valid, out_ar_ready = 1'b0;
    logic [31:0] out_r_data = '0;
    logic [1:0]  out_r_resp = '0;
    logic        out_r_valid = 1'b0, out_r_ready;

    axi_to_axi_lite_bridge #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(8), .AXI_USER_WIDTH(8)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .testmode_i(testmode_i),
        .in_aw_id(in_aw_id), .in_aw_addr(in_aw_addr), .in_aw_len(in_aw_len),
        .in_aw_size(in_aw_size), .in_aw_burst(in_aw_burst), .in_aw_lock(in_aw_lock),
        .in_aw_cache(in_aw_cache), .in_aw_prot(in_aw_prot), .in_aw_qos(in_aw_qos),
        .in_aw_region(in_aw_region), .in_aw_atop(in_aw_atop), .in_aw_user(in_aw_user),
        .in_aw_valid(in_aw_valid), .in_aw_ready(in_aw_ready),
        .in_w_data(in_w_data), .in_w_strb(in_w_strb), .in_w_last(in_w_last),
        .in_w_user(in_w_user), .in_w_valid(in_w_valid), .in_w_ready(in_w_ready),
        .in_b_id(in_b_id), .in_b_resp(in_b_resp), .in_b_user(in_b_user),
        .in_b_valid(in_b_valid), .in_b_ready(in_b_ready),
        .in_ar_id(in_ar_id), .in_ar_addr(in_ar_addr), .in_ar_len(in_ar_len),
        .in_ar_size(in_ar_size), .in_ar_burst(in_ar_burst), .in_ar_lock(in_ar_lock),
        .in_ar_cache(in_ar_cache), .in_ar_prot(in_ar_prot), .in_ar_qos(in_ar_qos),
        .in_ar_region(in_ar_region), .in_ar_user(in_ar_user),
        .in_ar_valid(in_ar_valid), .in_ar_ready(in_ar_ready),
        .in_r_id(in_r_id), .in_r_data(in_r_data), .in_r_resp(in_r_resp),
        .in_r_last(in_r_last), .in_r_user(in_r_user), .in_r_valid(in_r_valid),
        .in_r_ready(in_r_ready),
        .out_aw_addr(out_aw_addr), .out_aw_prot(out_aw_prot), .out_aw_valid(out_aw_valid),
        .out_aw_ready(out_aw_ready), .out_w_data(out_w_data), .out_w_strb(out_w_strb),
        .out_w_valid(out_w_valid), .out_w_ready(out_w_ready), .out_b_resp(out_b_resp),
        .out_b_valid(out_b_valid), .out_b_ready(out_b_ready),
        .out_ar_addr(out_ar_addr), .out_ar_prot(out_ar_prot), .out_ar_valid(out_ar_valid),
        .out_ar_ready(out_ar_ready), .out_r_data(out_r_data), .out_r_resp(out_r_resp),
        .out_r_valid(out_r_valid), .out_r_ready(out_r_ready)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0, failures = 0;
    int unsigned lite_aw_cycles = 0, lite_w_cycles = 0, lite_ar_cycles = 0;

    // Cycles during which each Lite request channel was presented.
    always @(posedge clk) begin
        if (!rst_i) begin
            if (out_aw_valid) lite_aw_cycles++;
            if (out_w_valid)  lite_w_cycles++;
            if (out_ar_valid) lite_ar_cycles++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [5:0] atop, input logic [31:0] data, input logic [3:0] strb,
                            input logic [1:0] lresp, input bit exp_lite, input logic [1:0] exp_resp,
                            input int aw_stall, input int b_stall);
        int n;
        int unsigned aw0, w0;
        aw0 = lite_aw_cycles; w0 = lite_w_cycles;
        @(negedge clk);
        in_aw_valid = 1'b1; in_aw_id = id; in_aw_addr = addr; in_aw_len = len; in_aw_atop = atop;
        in_aw_size = 3'd2; in_aw_burst = 2'b01; in_aw_cache = 4'hF; in_aw_prot = 3'h7;
        in_aw_qos = 4'h3; in_aw_region = 4'h5; in_aw_user = 8'hA5; in_aw_lock = 1'b1;
        n = 0;
        while (!in_aw_ready && n < 20) begin @(negedge clk); n++; end
        check("aw_ready", in_aw_ready, 1);
        @(negedge clk);
        in_aw_valid = 1'b0; in_aw_addr = '1; in_aw_id = ~id;
        if (exp_lite) begin
            check("lite_aw_latency", out_aw_valid, 1);
            check("lite_aw_addr", out_aw_addr, addr);
            check("lite_aw_prot", out_aw_prot, 0);
            // W offered early must be held off until the Lite AW is accepted.
            in_w_valid = 1'b1; in_w_data = data; in_w_strb = strb; in_w_last = 1'b1;
            out_w_ready = 1'b1;
            #1 check("w_held_off", {in_w_ready, out_w_valid}, 0);
            for (int i = 0; i < aw_stall; i++) begin
                @(negedge clk);
                #1 check("aw_hold", {out_aw_valid, out_aw_addr, in_w_ready, out_w_valid},
                         {1'b1, addr, 2'b00});
            end
            out_aw_ready = 1'b1;
            @(negedge clk);
            out_aw_ready = 1'b0; out_w_ready = 1'b0;
            for (int i = 0; i < aw_stall; i++) begin
                #1 check("w_hold", {out_w_valid, out_w_data, out_w_strb, in_w_ready, out_aw_valid},
                         {1'b1, data, strb, 2'b00});
                @(negedge clk);
            end
            out_w_ready = 1'b1;
            #1 check("lite_w", {out_w_valid, out_w_data, out_w_strb, in_w_ready},
                     {1'b1, data, strb, 1'b1});
            @(negedge clk);
            out_w_ready = 1'b0; in_w_valid = 1'b0;
            check("lite_b_ready", out_b_ready, 1);
            out_b_valid = 1'b1; out_b_resp = lresp;
            @(negedge clk);
            out_b_valid = 1'b0; out_b_resp = ~lresp;
        end else begin
            for (int b = 0; b <= int'(len); b++) begin
                in_w_valid = 1'b1; in_w_data = data + b; in_w_strb = strb; in_w_last = (b == int'(len));
                #1 check("err_w_sink", {in_w_ready, out_w_valid}, 2'b10);
                @(negedge clk);
            end
            in_w_valid = 1'b0; in_w_last = 1'b0;
        end
        check("b_latency", in_b_valid, 1);
        check("b_id", in_b_id, id);
        check("b_resp", in_b_resp, exp_resp);
        check("b_user", in_b_user, 0);
        for (int i = 0; i < b_stall; i++) begin
            @(negedge clk);
            check("b_hold", {in_b_valid, in_b_id, in_b_resp}, {1'b1, id, exp_resp});
        end
        in_b_ready = 1'b1;
        @(negedge clk);
        in_b_ready = 1'b0;
        check("b_done", in_b_valid, 0);
        check("lite_aw_count", lite_aw_cycles - aw0, exp_lite ? aw_stall + 1 : 0);
        check("lite_w_count", lite_w_cycles - w0, exp_lite ? aw_stall + 1 : 0);
    endtask

    task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] ldata, input logic [1:0] lresp,
                           input bit exp_lite, input logic [1:0] exp_resp, input int r_stall);
        int n;
        int unsigned ar0;
        ar0 = lite_ar_cycles;
        @(negedge clk);
        in_ar_valid = 1'b1; in_ar_id = id; in_ar_addr = addr; in_ar_len = len;
        in_ar_size = 3'd2; in_ar_burst = 2'b01; in_ar_cache = 4'hA; in_ar_prot = 3'h5;
        in_ar_user = 8'h5A; in_ar_lock = 1'b1;
        n = 0;
        while (!in_ar_ready && n < 20) begin @(negedge clk); n++; end
        check("ar_ready", in_ar_ready, 1);
        @(negedge clk);
        in_ar_valid = 1'b0; in_ar_addr = '1; in_ar_id = ~id;
        if (exp_lite) begin
            check("lite_ar", {out_ar_valid, out_ar_addr, out_ar_prot}, {1'b1, addr, 3'b000});
            out_ar_ready = 1'b1;
            @(negedge clk);
            out_ar_ready = 1'b0;
            check("lite_r_ready", out_r_ready, 1);
            out_r_valid = 1'b1; out_r_data = ldata; out_r_resp = lresp;
            @(negedge clk);
            out_r_valid = 1'b0; out_r_data = ~ldata; out_r_resp = ~lresp;
            check("r_beat", {in_r_valid, in_r_id, in_r_data, in_r_resp, in_r_last, in_r_user},
                  {1'b1, id, ldata, exp_resp, 1'b1, 8'h00});
            for (int i = 0; i < r_stall; i++) begin
                @(negedge clk);
                check("r_hold", {in_r_valid, in_r_id, in_r_data, in_r_resp},
                      {1'b1, id, ldata, exp_resp});
            end
            in_r_ready = 1'b1;
            @(negedge clk);
            in_r_ready = 1'b0;
        end else begin
            for (int b = 0; b <= int'(len); b++) begin
                check("err_r_beat", {in_r_valid, in_r_id, in_r_data, in_r_resp, in_r_last},
                      {1'b1, id, 32'h0, exp_resp, b == int'(len)});
                in_r_ready = 1'b1;
                @(negedge clk);
                in_r_ready = 1'b0;
            end
        end
        check("r_done", in_r_valid, 0);
        check("lite_ar_count", lite_ar_cycles - ar0, exp_lite ? 1 : 0);
    endtask

    typedef struct {
        bit          is_rd;
        logic [7:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [5:0]  atop;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  lresp;
        bit          exp_lite;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{1'b0, 8'h5A, 32'h1000_0010, 8'd0, 6'd0,    32'hDEAD_BEEF, 4'hF, 2'b00, 1'b1, 2'b00};
        vecs[1] = '{1'b1, 8'h33, 32'h0000_0004, 8'd0, 6'd0,    32'h0000_0000, 4'h0, 2'b00, 1'b1, 2'b00};
        vecs[2] = '{1'b0, 8'h11, 32'h2000_0000, 8'd0, 6'd0,    32'h1234_5678, 4'h3, 2'b10, 1'b1, 2'b10};
        vecs[3] = '{1'b1, 8'h22, 32'h3000_0008, 8'd0, 6'd0,    32'hCAFE_F00D, 4'h0, 2'b11, 1'b1, 2'b11};
        vecs[4] = '{1'b1, 8'h01, 32'h0000_0100, 8'd3, 6'd0,    32'h0000_0000, 4'h0, 2'b00, 1'b0, 2'b10};
        vecs[5] = '{1'b0, 8'h44, 32'h0000_0200, 8'd1, 6'd0,    32'hAAAA_0000, 4'hF, 2'b00, 1'b0, 2'b10};
        vecs[6] = '{1'b0, 8'h66, 32'h0000_0300, 8'd0, 6'h20,   32'hBBBB_0000, 4'hF, 2'b00, 1'b0, 2'b10};
        vecs[7] = '{1'b1, 8'hFF, 32'hFFFF_FFFC, 8'd0, 6'd0,    32'hA5A5_A5A5, 4'h0, 2'b01, 1'b1, 2'b01};
        vecs[8] = '{1'b0, 8'h00, 32'h8000_0000, 8'd0, 6'd0,    32'h0F0F_0F0F, 4'h0, 2'b01, 1'b1, 2'b01};

        #3;
        check("rst_valids", {in_b_valid, in_r_valid, out_aw_valid, out_w_valid, out_ar_valid}, 0);
        check("rst_readies", {in_aw_ready, in_ar_ready, in_w_ready, out_b_ready, out_r_ready}, 5'b11000);
        @(negedge clk); @(negedge clk);
        rst_i = 1'b0;

        for (int v = 0; v < 9; v++) begin
            if (vecs[v].is_rd)
                do_read(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].data, vecs[v].lresp,
                        vecs[v].exp_lite, vecs[v].exp_resp, 0);
            else
                do_write(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].atop, vecs[v].data,
                         vecs[v].strb, vecs[v].lresp, vecs[v].exp_lite, vecs[v].exp_resp, 0, 0);
        end

        // Backpressure on the write path while a read runs alongside.
        fork
            do_write(8'h7E, 32'h4000_0040, 8'd0, 6'd0, 32'h0BAD_CAFE, 4'h9, 2'b00, 1'b1, 2'b00, 5, 3);
            do_read(8'h3C, 32'h4000_0080, 8'd0, 32'h5555_AAAA, 2'b00, 1'b1, 2'b00, 2);
        join

        // Reset while the write waits for B and an error read is streaming.
        @(negedge clk);
        in_aw_valid = 1'b1; in_aw_id = 8'h12; in_aw_addr = 32'h5000_0000; in_aw_len = 8'd0;
        in_aw_atop = 6'd0;
        in_ar_valid = 1'b1; in_ar_id = 8'h34; in_ar_len = 8'd2;
        @(negedge clk);
        in_aw_valid = 1'b0; in_ar_valid = 1'b0;
        out_aw_ready = 1'b1;
        @(negedge clk);
        out_aw_ready = 1'b0;
        in_w_valid = 1'b1; in_w_last = 1'b1; out_w_ready = 1'b1;
        @(negedge clk);
        in_w_valid = 1'b0; out_w_ready = 1'b0;
        check("pre_rst_state", {out_b_ready, in_r_valid}, 2'b11);
        #2 rst_i = 1'b1;
        #1 check("async_rst", {out_b_ready, in_r_valid, in_b_valid, out_aw_valid, out_ar_valid,
                                out_w_valid, out_r_ready}, 0);
        @(negedge clk);
        rst_i = 1'b0;
        check("post_rst_idle", {in_aw_ready, in_ar_ready, in_b_valid, in_r_valid}, 4'b1100);
        do_write(8'h9C, 32'h6000_0004, 8'd0, 6'd0, 32'h1357_9BDF, 4'hC, 2'b00, 1'b1, 2'b00, 0, 1);
        do_read(8'h9D, 32'h6000_0008, 8'd0, 32'h2468_ACE0, 2'b00, 1'b1, 2'b00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
